// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and an external
// loader/debug port; CPU has priority, external port is protected from starvation.
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_stall,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       ext_req,
  input  logic       ext_we,
  input  logic [7:0] ext_addr,
  input  logic [7:0] ext_wdata,
  output logic       ext_gnt,
  output logic [7:0] ext_rdata,
  output logic       ext_rvalid,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } rd_owner_t;

  rd_owner_t        rd_owner, rd_owner_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             cpu_win, ext_win;

  // State register: read-return owner and external wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner   <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      rd_owner   <= rd_owner_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Grant decision, memory drive and next-state logic
  always_comb begin
    cpu_win        = 1'b0;
    ext_win        = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    rd_owner_nxt   = OWN_NONE;
    starve_cnt_nxt = '0;

    if (!rst) begin
      if (cpu_req && !(ext_req && (starve_cnt == LIMIT))) begin
        cpu_win = 1'b1;
      end else if (ext_req) begin
        ext_win = 1'b1;
      end
    end

    if (cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (!cpu_we) rd_owner_nxt = OWN_CPU;
    end else if (ext_win) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      if (!ext_we) rd_owner_nxt = OWN_EXT;
    end

    // Saturating count of consecutive denied external cycles
    if (ext_req && !ext_win) begin
      starve_cnt_nxt = (starve_cnt == LIMIT) ? starve_cnt : CNT_W'(starve_cnt + 1'b1);
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_win & ~rst;
  assign ext_gnt    = ext_win;

  // A read in flight when rst rises is dropped immediately, not one cycle late
  assign cpu_rvalid = (rd_owner == OWN_CPU) & ~rst;
  assign ext_rvalid = (rd_owner == OWN_EXT) & ~rst;
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: the driver queues expected grant/memory
// state and read responses, a negedge monitor pops and compares them.
module tb_dm_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_stall;
  logic [7:0] cpu_rdata;
  logic       cpu_rvalid;
  logic       ext_req, ext_we;
  logic [7:0] ext_addr, ext_wdata;
  logic       ext_gnt;
  logic [7:0] ext_rdata;
  logic       ext_rvalid;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;

  dm_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       stall;
    logic       gnt;
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ctl_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rsp_t;

  ctl_t ctl_q[$];
  rsp_t cpu_q[$];
  rsp_t ext_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus plus its hand-computed expectation
  task automatic step(input logic r,
                      input logic creq, input logic cwe, input logic [7:0] caddr, input logic [7:0] cwd,
                      input logic ereq, input logic ewe, input logic [7:0] eaddr, input logic [7:0] ewd,
                      input logic x_stall, input logic x_gnt, input logic [7:0] x_rdata, input logic x_resp);
    ctl_t c;
    rsp_t s;
    logic cwin;
    @(posedge clk);
    #1;
    rst = r;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    ext_req = ereq; ext_we = ewe; ext_addr = eaddr; ext_wdata = ewd;
    cwin = creq & ~x_stall & ~r;
    c.stall = x_stall;
    c.gnt   = x_gnt;
    c.en    = cwin | x_gnt;
    c.we    = cwin ? cwe : (x_gnt ? ewe : 1'b0);
    c.addr  = cwin ? caddr : (x_gnt ? eaddr : 8'h00);
    c.wdata = cwin ? cwd : (x_gnt ? ewd : 8'h00);
    ctl_q.push_back(c);
    s.data = x_rdata;
    s.due  = cyc + 1;
    if (x_resp && cwin && !cwe)   cpu_q.push_back(s);
    if (x_resp && x_gnt && !ewe)  ext_q.push_back(s);
  endtask

  // Monitor: compares control every cycle, read responses when due
  initial begin
    ctl_t e;
    logic exp_v;
    forever begin
      @(negedge clk);
      if (ctl_q.size() > 0) begin
        e = ctl_q.pop_front();
        chk("cpu_stall", 8'(cpu_stall), 8'(e.stall));
        chk("ext_gnt",   8'(ext_gnt),   8'(e.gnt));
        chk("mem_en",    8'(mem_en),    8'(e.en));
        chk("mem_we",    8'(mem_we),    8'(e.we));
        chk("mem_addr",  mem_addr,      e.addr);
        chk("mem_wdata", mem_wdata,     e.wdata);
      end
      while (cpu_q.size() > 0 && cpu_q[0].due < cyc) begin
        chk("cpu_rsp_late", 8'(cpu_q[0].due), 8'(cyc));
        void'(cpu_q.pop_front());
      end
      exp_v = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
      chk("cpu_rvalid", 8'(cpu_rvalid), 8'(exp_v));
      if (exp_v) begin
        if (cpu_rvalid) chk("cpu_rdata", cpu_rdata, cpu_q[0].data);
        void'(cpu_q.pop_front());
      end
      while (ext_q.size() > 0 && ext_q[0].due < cyc) begin
        chk("ext_rsp_late", 8'(ext_q[0].due), 8'(cyc));
        void'(ext_q.pop_front());
      end
      exp_v = (ext_q.size() > 0) && (ext_q[0].due == cyc);
      chk("ext_rvalid", 8'(ext_rvalid), 8'(exp_v));
      if (exp_v) begin
        if (ext_rvalid) chk("ext_rdata", ext_rdata, ext_q[0].data);
        void'(ext_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 8'h00;

    // Reset with both ports requesting: nothing granted
    step(1, 1,0,8'h00,8'h00, 1,0,8'h01,8'h00, 0,0,8'h00,0);
    step(1, 1,0,8'h00,8'h00, 1,0,8'h01,8'h00, 0,0,8'h00,0);
    // First cycle out of reset: CPU wins (preload 0x20 = 0x3C)
    step(0, 1,1,8'h20,8'h3C, 1,0,8'h01,8'h00, 0,0,8'h00,0);
    // CPU write then read
    step(0, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,8'h00,0);
    step(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,8'hA5,1);
    // External alone
    step(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,1,8'h3C,1);
    // Starvation, limit 3: ext write wins on 4th contended cycle
    for (int i = 0; i < 3; i++)
      step(0, 1,0,8'h10,8'h00, 1,1,8'h40,8'h77, 0,0,8'hA5,1);
    step(0, 1,0,8'h10,8'h00, 1,1,8'h40,8'h77, 1,1,8'h00,0);
    for (int i = 0; i < 3; i++)
      step(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,8'hA5,1);
    step(0, 1,0,8'h40,8'h00, 0,0,8'h00,8'h00, 0,0,8'h77,1);
    // Interleaved reads across ports
    step(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,8'hA5,1);
    step(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,1,8'h3C,1);
    // ext_req drop clears the counter
    for (int i = 0; i < 2; i++)
      step(0, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 0,0,8'hA5,1);
    step(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,8'hA5,1);
    for (int i = 0; i < 3; i++)
      step(0, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 0,0,8'hA5,1);
    step(0, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,1,8'h3C,1);
    // Reset mid-read: response discarded
    step(0, 1,0,8'h20,8'h00, 0,0,8'h00,8'h00, 0,0,8'h00,0);
    step(1, 1,0,8'h20,8'h00, 0,0,8'h00,8'h00, 0,0,8'h00,0);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,8'h00,0);
    step(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,8'hA5,1);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,8'h00,0);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,8'h00,0);
    @(posedge clk);
    @(negedge clk);
    chk("cpu_q_drained", 8'(cpu_q.size()), 8'd0);
    chk("ext_q_drained", 8'(ext_q.size()), 8'd0);
    chk("ctl_q_drained", 8'(ctl_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbiter sharing the single-port 8-bit data memory between the pipeline MEM stage and an external loader/debug port. The CPU port has priority. The external port is protected from starvation by a bounded wait counter. The block stalls the pipeline while the CPU loses arbitration and routes each synchronous-read result back to the port that issued the read.

## Interface
- STARVE_LIMIT, 8: consecutive denied external-request cycles before the external port is forced to win; legal range 1..15.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  MEM-stage access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  8  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_stall  out  1  CPU request not granted this cycle; pipeline holds
- cpu_rdata  out  8  read data returned to the CPU
- cpu_rvalid  out  1  cpu_rdata valid
- ext_req  in  1  external access request; held until granted
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  8  external address
- ext_wdata  in  8  external write data
- ext_gnt  out  1  external request accepted this cycle
- ext_rdata  out  8  read data returned to the external port
- ext_rvalid  out  1  ext_rdata valid
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  8  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid one cycle after the read enable

## Operation
- Grant decision is combinational, one winner per cycle:
  - only one port requesting: that port wins;
  - both requesting, starve_cnt < STARVE_LIMIT: CPU wins;
  - both requesting, starve_cnt == STARVE_LIMIT: external wins.
- Memory drive:
  - mem_en = 1 when any port wins.
  - mem_we, mem_addr and mem_wdata come from the winner.
  - With no winner, mem_we = 0 and mem_addr/mem_wdata = 0.
- cpu_stall = cpu_req & ~cpu_win.
- ext_gnt = ext_win.
- starve_cnt (4-bit register) updates each cycle:
  - ext_req & ~ext_gnt: increment, saturating at STARVE_LIMIT;
  - otherwise: clear to 0.
- rd_owner register takes one of three values:
  - NONE when the cycle has no read winner;
  - CPU when the CPU wins with a read (we = 0);
  - EXT when the external port wins with a read.
- Read return:
  - cpu_rvalid = (rd_owner == CPU) and ext_rvalid = (rd_owner == EXT), both registered.
  - cpu_rdata and ext_rdata both carry mem_rdata; each is meaningful only while its rvalid is high.
- Writes are complete at grant; they produce no response and set rd_owner to NONE.
- During rst, all grants are forced to 0: mem_en = 0, cpu_stall = 0, ext_gnt = 0.

## Timing
- Reset values:
  - starve_cnt = 0, rd_owner = NONE;
  - cpu_rvalid = ext_rvalid = 0;
  - cpu_stall = ext_gnt = mem_en = mem_we = 0;
  - mem_addr = mem_wdata = 0.
- Grant latency is 0 cycles: a request with no contender is granted in the same cycle.
- Read latency: granted at cycle N, rvalid and data at cycle N+1.
- Back-to-back reads are legal from either port, and across ports, one per cycle.
- Worst-case external wait is STARVE_LIMIT cycles denied, then granted on cycle STARVE_LIMIT+1.
  - The CPU is stalled exactly 1 cycle per forced external win.
  - The counter clears on that grant.
- ext_req dropping before grant clears starve_cnt, so the next request starts from 0.
- rst asserted mid-operation:
  - an outstanding read is discarded: no rvalid on the cycle after rst;
  - the counter clears;
  - the first grant occurs on the first cycle with rst low.
- A CPU request held under stall keeps its address stable. When finally granted, the access executes once; no duplicate write occurs.

## Test plan
- Reset state: rst high for 2 cycles with both requests high -> mem_en = 0, cpu_stall = 0, ext_gnt = 0, both rvalid = 0. First cycle after rst -> CPU wins.
- CPU write then read: cpu write addr 0x10 data 0xA5, next cycle cpu read 0x10 -> mem_we = 1 on the first cycle; cpu_rvalid = 1 with cpu_rdata = 0xA5 one cycle after the read grant; cpu_stall = 0 throughout.
- External alone: ext read 0x20 (memory holds 0x3C) -> ext_gnt same cycle; ext_rvalid = 1 and ext_rdata = 0x3C next cycle; cpu_rvalid stays 0.
- Starvation, STARVE_LIMIT = 3, both requesting continuously:
  - cycles 0-2: CPU wins, starve_cnt goes 1, 2, 3;
  - cycle 3: ext_gnt = 1, cpu_stall = 1, counter returns to 0;
  - cycles 4-6: CPU wins again.
- Interleaved reads: CPU read at cycle N, external read at cycle N+1 -> cpu_rvalid at N+1 only, ext_rvalid at N+2 only, each carrying the correct data.
- Reset mid-read: CPU read granted at cycle N, rst high at N+1 -> cpu_rvalid = 0 at N+1 and N+2.
